// File: rtl/pipe_wb_pkg.sv
// CP0 register numbers, exception codes and register field positions shared by the WB stage.
package cp0_defs;

    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int unsigned STATUS_BEV_BIT = 22;
    localparam int unsigned STATUS_IM_LSB  = 8;
    localparam int unsigned STATUS_EXL_BIT = 1;
    localparam int unsigned STATUS_IE_BIT  = 0;

    localparam int unsigned CAUSE_BD_BIT  = 31;
    localparam int unsigned CAUSE_TI_BIT  = 30;
    localparam int unsigned CAUSE_IP_LSB  = 8;
    localparam int unsigned CAUSE_EXC_LSB = 2;

    // A delay-slot instruction restarts at its branch.
    function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
        return bd ? (pc - 32'd4) : pc;
    endfunction

endpackage

// File: rtl/pipe_wb_cp0_regfile.sv
// CP0 register file: Count/Compare/Status/Cause/EPC, read mux, timer interrupt and int_pending.
module cp0_regfile
    import cp0_defs::*;
#(
    parameter logic [31:0] STATUS_RESET = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        take_ex,
    input  logic        eret_c,
    input  logic        mtc0_we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    input  logic [31:0] ex_pc,
    input  logic        ex_bd,
    input  logic [4:0]  ex_code,
    input  logic [5:0]  hw_int,
    output logic [31:0] cp0_rdata,
    output logic [31:0] epc,
    output logic        int_pending
);

    logic [31:0] count_q, count_d;
    logic        tick_q, tick_d;
    logic [31:0] compare_q, compare_d;
    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic        ti_q, ti_d;
    logic [5:0]  ip_hw_q, ip_hw_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [31:0] epc_q, epc_d;

    logic wr_count, wr_compare, wr_status, wr_cause, wr_epc;

    always_comb begin
        wr_count   = mtc0_we && (cp0_addr == CP0_COUNT);
        wr_compare = mtc0_we && (cp0_addr == CP0_COMPARE);
        wr_status  = mtc0_we && (cp0_addr == CP0_STATUS);
        wr_cause   = mtc0_we && (cp0_addr == CP0_CAUSE);
        wr_epc     = mtc0_we && (cp0_addr == CP0_EPC);
    end

    always_comb begin
        tick_d     = ~tick_q;
        count_d    = tick_q ? (count_q + 32'd1) : count_q;
        compare_d  = compare_q;
        ti_d       = ti_q;
        ip_hw_d    = {hw_int[5] | ti_q, hw_int[4:0]};
        ip_sw_d    = ip_sw_q;
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;

        if (wr_count) begin
            count_d = cp0_wdata;
        end
        if (count_q == compare_q) begin
            ti_d = 1'b1;
        end
        // Writing Compare acknowledges the timer, even against a same-cycle match.
        if (wr_compare) begin
            compare_d = cp0_wdata;
            ti_d      = 1'b0;
        end
        if (wr_status) begin
            im_d  = cp0_wdata[STATUS_IM_LSB +: 8];
            exl_d = cp0_wdata[STATUS_EXL_BIT];
            ie_d  = cp0_wdata[STATUS_IE_BIT];
        end
        if (wr_cause) begin
            ip_sw_d = cp0_wdata[CAUSE_IP_LSB +: 2];
        end
        if (wr_epc) begin
            epc_d = cp0_wdata;
        end

        if (eret_c) begin
            exl_d = 1'b0;
        end

        // Nested exceptions keep the original return point.
        if (take_ex) begin
            exl_d      = 1'b1;
            exc_code_d = ex_code;
            if (!exl_q) begin
                epc_d = epc_of(ex_pc, ex_bd);
                bd_d  = ex_bd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            tick_q     <= 1'b0;
            compare_q  <= '0;
            im_q       <= STATUS_RESET[STATUS_IM_LSB +: 8];
            exl_q      <= STATUS_RESET[STATUS_EXL_BIT];
            ie_q       <= STATUS_RESET[STATUS_IE_BIT];
            bd_q       <= 1'b0;
            ti_q       <= 1'b0;
            ip_hw_q    <= '0;
            ip_sw_q    <= '0;
            exc_code_q <= '0;
            epc_q      <= '0;
        end else begin
            count_q    <= count_d;
            tick_q     <= tick_d;
            compare_q  <= compare_d;
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ti_q       <= ti_d;
            ip_hw_q    <= ip_hw_d;
            ip_sw_q    <= ip_sw_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
        end
    end

    always_comb begin
        cp0_rdata = '0;
        case (cp0_addr)
            CP0_COUNT:   cp0_rdata = count_q;
            CP0_COMPARE: cp0_rdata = compare_q;
            CP0_STATUS: begin
                cp0_rdata[STATUS_BEV_BIT]      = 1'b1;
                cp0_rdata[STATUS_IM_LSB +: 8]  = im_q;
                cp0_rdata[STATUS_EXL_BIT]      = exl_q;
                cp0_rdata[STATUS_IE_BIT]       = ie_q;
            end
            CP0_CAUSE: begin
                cp0_rdata[CAUSE_BD_BIT]        = bd_q;
                cp0_rdata[CAUSE_TI_BIT]        = ti_q;
                cp0_rdata[CAUSE_IP_LSB +: 8]   = {ip_hw_q, ip_sw_q};
                cp0_rdata[CAUSE_EXC_LSB +: 5]  = exc_code_q;
            end
            CP0_EPC:     cp0_rdata = epc_q;
            default:     cp0_rdata = '0;
        endcase
    end

    assign epc         = epc_q;
    assign int_pending = ie_q & ~exl_q & (|({ip_hw_q, ip_sw_q} & im_q));

endmodule

// File: rtl/pipe_wb.sv
// Write-back stage: latches the MEM result, commits GPR writes and is the single commit point
// for exceptions, interrupts and ERET. Define WB_DEBUG_TRACE_EN to add the debug trace ports.
module pipe_wb
    import cp0_defs::*;
#(
    parameter logic [31:0] EX_VECTOR    = 32'hBFC0_0380,
    parameter logic [31:0] STATUS_RESET = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_wb_validto,
    input  logic [31:0] pc_in,
    input  logic [31:0] rt_in,
    input  logic [31:0] wb_result_in,
    input  logic [4:0]  rdc_in,
    input  logic        rf_we_in,
    input  logic        bypass_rdc_valid_in,
    input  logic        mfc0_instr_in,
    input  logic        ex_in,
    input  logic [4:0]  ex_code_in,
    input  logic        cp0_rd_mux_sel_in,
    input  logic        cp0_we_in,
    input  logic [4:0]  cp0_rdc_in,
    input  logic        eret_flush_in,
    input  logic        branch_delay_in,
    input  logic [5:0]  hw_int,
    output logic        wb_allowin,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] bypass_wb,
    output logic        wb_rdc_valid,
    output logic        wb_mfc0_instr,
    output logic        ex_wb,
    output logic        flush,
    output logic [31:0] flush_pc,
    output logic [31:0] cp0_epc
`ifdef WB_DEBUG_TRACE_EN
    ,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_wen,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
`endif
);

    localparam logic WB_READY_GO = 1'b1;

    logic        wb_valid_q;
    logic [31:0] pc_q, rt_q, result_q;
    logic [4:0]  rdc_q, ex_code_q, cp0_rdc_q;
    logic        rf_we_q, rdc_valid_q, mfc0_q, ex_q, mux_q, cp0_we_q, eret_q, bd_q;

    logic        take_ex, eret_c, mtc0_we, int_pending;
    logic [4:0]  commit_code;
    logic [31:0] cp0_rdata, epc_raw;

    assign wb_allowin = !wb_valid_q | WB_READY_GO;

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_q <= 1'b0;
        end else if (wb_allowin) begin
            wb_valid_q <= mem_wb_validto;
        end
    end

    // Payload is qualified by wb_valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (mem_wb_validto && wb_allowin) begin
            pc_q        <= pc_in;
            rt_q        <= rt_in;
            result_q    <= wb_result_in;
            rdc_q       <= rdc_in;
            rf_we_q     <= rf_we_in;
            rdc_valid_q <= bypass_rdc_valid_in;
            mfc0_q      <= mfc0_instr_in;
            ex_q        <= ex_in;
            ex_code_q   <= ex_code_in;
            mux_q       <= cp0_rd_mux_sel_in;
            cp0_we_q    <= cp0_we_in;
            cp0_rdc_q   <= cp0_rdc_in;
            eret_q      <= eret_flush_in;
            bd_q        <= branch_delay_in;
        end
    end

    always_comb begin
        take_ex     = wb_valid_q & (ex_q | int_pending);
        eret_c      = wb_valid_q & eret_q & ~take_ex;
        mtc0_we     = wb_valid_q & cp0_we_q & ~take_ex;
        commit_code = int_pending ? EXC_INT : ex_code_q;
    end

    cp0_regfile #(
        .STATUS_RESET (STATUS_RESET)
    ) u_cp0 (
        .clk         (clk),
        .rst         (rst),
        .take_ex     (take_ex),
        .eret_c      (eret_c),
        .mtc0_we     (mtc0_we),
        .cp0_addr    (cp0_rdc_q),
        .cp0_wdata   (rt_q),
        .ex_pc       (pc_q),
        .ex_bd       (bd_q),
        .ex_code     (commit_code),
        .hw_int      (hw_int),
        .cp0_rdata   (cp0_rdata),
        .epc         (epc_raw),
        .int_pending (int_pending)
    );

    always_comb begin
        rf_we         = wb_valid_q & rf_we_q & ~take_ex;
        rf_waddr      = wb_valid_q ? rdc_q : 5'd0;
        rf_wdata      = wb_valid_q ? (mux_q ? cp0_rdata : result_q) : 32'd0;
        wb_rdc_valid  = wb_valid_q & rdc_valid_q;
        wb_mfc0_instr = wb_valid_q & mfc0_q;
        ex_wb         = take_ex;
        flush         = take_ex | eret_c;
        flush_pc      = take_ex ? EX_VECTOR : epc_raw;
        cp0_epc       = wb_valid_q ? epc_raw : 32'd0;
    end

    assign bypass_wb = rf_wdata;

`ifdef WB_DEBUG_TRACE_EN
    assign debug_wb_pc       = wb_valid_q ? pc_q : 32'd0;
    assign debug_wb_rf_wen   = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;
`endif

endmodule

// File: doc/pipe_wb.md
Name: pipe_wb

Overview:
Write-back stage directly downstream of the memory stage. It latches the memory stage's result through the valid/allowin handshake and commits the register-file write. It owns the CP0 register file and is the single commit point for exceptions, interrupts and ERET. On any of these it drives the pipeline flush and the redirect PC.

Parameters:
EX_VECTOR, 32'hBFC0_0380, exception/interrupt entry PC
STATUS_RESET, 32'h0040_0000, CP0 Status reset value (BEV=1)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
mem_wb_validto  in  1  memory stage has a valid instruction for WB
pc_in  in  32  instruction PC
rt_in  in  32  MTC0 write data
wb_result_in  in  32  ALU/load/HI/LO result
rdc_in  in  5  destination GPR
rf_we_in  in  1  GPR write request
bypass_rdc_valid_in  in  1  rdc is a real destination
mfc0_instr_in  in  1  instruction is MFC0
ex_in  in  1  upstream-detected exception
ex_code_in  in  5  exception code
cp0_rd_mux_sel_in  in  1  1: GPR data comes from the CP0 read
cp0_we_in  in  1  MTC0
cp0_rdc_in  in  5  CP0 register number
eret_flush_in  in  1  ERET
branch_delay_in  in  1  instruction is in a delay slot
hw_int  in  6  external interrupt lines, level
wb_allowin  out  1  WB can accept
rf_we  out  1  GPR write enable
rf_waddr  out  5  GPR address
rf_wdata  out  32  GPR data
bypass_wb  out  32  forwarding value (equals rf_wdata)
wb_rdc_valid  out  1  bypass_rdc_valid & wb_valid
wb_mfc0_instr  out  1  MFC0 in WB (load-use style stall source)
ex_wb  out  1  exception or interrupt committing this cycle
flush  out  1  pipeline flush (ex_wb | ERET commit)
flush_pc  out  32  redirect target
cp0_epc  out  32  current EPC

Behaviour:
- wb_ready_go=1. wb_allowin = !wb_valid | wb_ready_go (always 1).
- wb_valid: reset 0. When wb_allowin, load mem_wb_validto.
- Payload registers load when mem_wb_validto & wb_allowin, else hold. Payload is not reset.
- int_pending = Status.IE & !Status.EXL & |(Cause.IP[7:0] & Status.IM[7:0]).
- take_ex = wb_valid & (ex | int_pending). An interrupt overrides ex_code with ExcCode 0.
- eret_c = wb_valid & eret & !take_ex.
- ex_wb=take_ex. flush=take_ex|eret_c, both combinational in the same cycle.
- flush_pc = take_ex ? EX_VECTOR : EPC.
- rf_we = wb_valid & rf_we_r & !take_ex.
- rf_wdata = cp0_rd_mux_sel ? cp0_rdata : result.
- All outputs are 0 when wb_valid=0, except flush_pc, which is don't-care.
- CP0 registers:
  - Count(9): increments every second clk via a toggle bit; reset 0.
  - Compare(11).
  - Status(12): bit22 BEV reads 1 and is read-only; IM[15:8] RW; EXL bit1; IE bit0.
  - Cause(13): BD bit31; TI bit30; IP[15:10] = {hw_int[5] | TI, hw_int[4:0]}, sampled each cycle; IP[9:8] RW; ExcCode[6:2].
  - EPC(14).
  - Reset: Status=STATUS_RESET; Cause, Compare, EPC, Count = 0.
  - Unimplemented reads return 0. Writes to unimplemented registers are ignored.
- Update priority per cycle: rst > take_ex > eret_c > MTC0 write (wb_valid & cp0_we & !take_ex).
- take_ex:
  - EXL <= 1; ExcCode <= code.
  - If old EXL=0: EPC <= BD ? pc-4 : pc, and Cause.BD <= BD.
  - If old EXL=1: EPC and BD unchanged.
- eret_c: EXL <= 0.
- TI: set when Count==Compare. Cleared by an MTC0 to Compare, which wins over a same-cycle set.
- An MTC0 to Count overrides that cycle's increment.
- Reset mid-operation: wb_valid cleared, nothing commits, CP0 returns to reset values.

Optional Feature:
WB_DEBUG_TRACE_EN
- Defined: adds outputs debug_wb_pc[31:0], debug_wb_rf_wen[3:0] (rf_we replicated), debug_wb_rf_wnum[4:0] and debug_wb_rf_wdata[31:0] for golden-trace comparison.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Package cp0_defs: CP0 register numbers (COUNT=9, COMPARE=11, STATUS=12, CAUSE=13, EPC=14), ExcCode constants (INT=0, ADEL=4, ADES=5, SYS=8, BP=9, RI=10, OV=12), Status/Cause bit positions.
- One sub-module, cp0_regfile. It holds the registers, read mux, Count/TI logic and int_pending.
- pipe_wb holds the handshake, the payload register and the commit/flush logic.

Test Plan:
- ALU result 0x1234 with rdc=8 and rf_we=1 through the handshake -> next cycle rf_we=1, waddr=8, wdata=0x1234, wb_rdc_valid=1. Following cycle with no new valid -> rf_we=0.
- ex_in=1, code=12 (OV), pc=0xBFC0_0100, BD=0 -> ex_wb=1, flush=1, flush_pc=0xBFC0_0380, rf_we=0. Next cycle EPC=0xBFC0_0100, Cause.ExcCode=12, EXL=1.
- Delay-slot exception at pc=0x8000_0024, BD=1 -> EPC=0x8000_0020, Cause.BD=1. A second exception while EXL=1 leaves EPC unchanged.
- ERET with EPC=0x8000_1000 -> flush=1, flush_pc=0x8000_1000, EXL cleared next cycle, ex_wb=0.
- MTC0 Status=0x0000_0401 (IM2, IE) then hw_int[0]=1 at the next valid instruction -> take_ex with ExcCode 0, that instruction's rf write suppressed, EPC=its pc.
- Compare=4 written -> TI set when Count reaches 4 (about 8 clk). MTC0 Compare clears TI. Assert rst mid-stream -> Status=0x0040_0000, wb_valid=0.
